hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the pipelined RV32I core that succeeds the single-cycle pd4 datapath. It generalises the fixed one-entry writeback bypass into MEM/WB priority forwarding. It adds load-use stalls with parametrised load latency and branch/jump redirect flushes with a parametrised penalty. It sits beside the decode/execute boundary and drives the stall and flush inputs of the F/D and D/E pipeline registers.

Parameters:
DWIDTH, 32, register data width
LOAD_LAT, 1, cycles a load result is unavailable after leaving EX (legal 0..3)
BR_PENALTY, 1, cycles of younger-stage flush after a redirect (legal 1..3)

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
d_rs1  input  5  decode-stage rs1 index
d_rs2  input  5  decode-stage rs2 index
d_rs1_used  input  1  decode instruction reads rs1
d_rs2_used  input  1  decode instruction reads rs2
e_valid  input  1  EX holds a real instruction
e_rd  input  5  EX destination
e_is_load  input  1  EX instruction is a load
e_redirect  input  1  EX resolved a taken branch, JAL or JALR
m_regwren  input  1  MEM-stage instruction writes rd
m_rd  input  5  MEM destination
m_data  input  DWIDTH  MEM result (ALU result or PC+4)
w_regwren  input  1  WB-stage instruction writes rd
w_rd  input  5  WB destination
w_data  input  DWIDTH  WB final writeback data
rf_rs1_data  input  DWIDTH  register file rs1 read data
rf_rs2_data  input  DWIDTH  register file rs2 read data
rs1_data_o  output  DWIDTH  forwarded rs1 operand
rs2_data_o  output  DWIDTH  forwarded rs2 operand
stall_f_o  output  1  hold PC
stall_d_o  output  1  hold F/D register
flush_d_o  output  1  bubble F/D register
flush_e_o  output  1  bubble D/E register

Behaviour:
- Forwarding (combinational), per operand: index 0 -> rf data (always zero). Otherwise MEM match (m_regwren, m_rd == rs) wins over WB match (w_regwren, w_rd == rs), which wins over rf data. The _used flags do not gate forwarding, only hazard detection.
- Load-use hazard: e_valid & e_is_load & e_rd != 0 & ((d_rs1_used & d_rs1 == e_rd) | (d_rs2_used & d_rs2 == e_rd)), with LOAD_LAT > 0. For LOAD_LAT = 0 the hazard is never raised.
- FSM states: RUN, STALL, FLUSH. 2-bit counter cnt.
- RUN: on e_redirect -> FLUSH, cnt = BR_PENALTY-1. Else on hazard -> STALL, cnt = LOAD_LAT-1. Outputs in RUN are combinational from the detected event, so the stall or flush takes effect in the detecting cycle.
- STALL: stall_f_o = stall_d_o = flush_e_o = 1. cnt decrements each cycle; exit to RUN when cnt == 0 and the hazard is gone. The total stall is exactly LOAD_LAT cycles.
- FLUSH: flush_d_o = flush_e_o = 1, no stall. cnt decrements; RUN when cnt == 0. Total flush is exactly BR_PENALTY cycles including the redirect cycle.
- Simultaneous redirect and hazard: the redirect wins, and no stall is issued.
- Redirect during STALL: abort the stall and enter FLUSH.
- Redirect during FLUSH: reload cnt and extend the flush.
- Hazard during FLUSH: ignored.
- Reset (asynchronous, rst = 0): state RUN, cnt 0. All stall and flush outputs read 0; the data outputs follow the combinational mux.
- Deassertion of rst is synchronised externally. Reset mid-STALL or mid-FLUSH abandons the sequence immediately.

Optional Feature:
HAZARD_STATS_EN: adds two 32-bit saturating counters, stall_cycles_o and flush_cycles_o. Both are cleared by reset and increment each cycle the FSM is in STALL or FLUSH respectively (including RUN-cycle detections). Without the macro these ports and registers do not exist.

Test Plan:
- Forward priority: m_rd = w_rd = 5, m_data = 0xAAAA0000, w_data = 0x5555, d_rs1 = 5 -> rs1_data_o = 0xAAAA0000. Drop m_regwren -> 0x5555.
- x0 guard: m_rd = 0, m_regwren = 1, m_data = 0xFFFFFFFF, d_rs2 = 0, rf = 0 -> rs2_data_o = 0.
- Load-use, LOAD_LAT = 2: load e_rd = 7, d_rs1 = 7, d_rs1_used = 1 -> stall_f/stall_d/flush_e high for exactly 2 cycles, then low.
- Redirect, BR_PENALTY = 2: e_redirect pulse -> flush_d/flush_e high for exactly 2 cycles. Asserted in the same cycle as a load-use hazard -> no stall_f.
- Redirect mid-stall (LOAD_LAT = 3), pulse in the 2nd stall cycle -> stall drops that cycle, flush runs BR_PENALTY cycles.
- Async reset: assert rst = 0 mid-FLUSH, off-clock-edge -> all control outputs 0 before the next edge; HAZARD_STATS_EN counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and forwarding controller for the pipelined RV32I core. It sits at
// the decode/execute boundary and:
//   * forwards MEM/WB results onto the decode operands (MEM has priority),
//   * stalls fetch/decode and bubbles D/E on a load-use hazard for LOAD_LAT
//     cycles,
//   * flushes F/D and D/E for BR_PENALTY cycles on a taken branch/jump.
//
// Parameters:
//   DWIDTH     register data width
//   LOAD_LAT   cycles a load result is unavailable after leaving EX (0..3)
//   BR_PENALTY cycles of younger-stage flush after a redirect (1..3)
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   d_rs1/d_rs2, *_used       decode source indices and read enables
//   e_valid/e_rd/e_is_load    EX instruction info for load-use detection
//   e_redirect                EX resolved a taken branch/JAL/JALR
//   m_regwren/m_rd/m_data     MEM-stage writer
//   w_regwren/w_rd/w_data     WB-stage writer
//   rf_rs1_data/rf_rs2_data   register file read data
//   rs1_data_o/rs2_data_o     forwarded operands
//   stall_f_o/stall_d_o       hold PC / hold F/D register
//   flush_d_o/flush_e_o       bubble F/D / bubble D/E register
//   dbg_state_o               FSM state (RUN=0, STALL=1, FLUSH=2)
//   stall_cycles_o            (HAZARD_STATS_EN only) saturating stall count
//   flush_cycles_o            (HAZARD_STATS_EN only) saturating flush count
//
// Optional build macro: HAZARD_STATS_EN adds the two statistics counters.
//
// Handshake note: there is no valid/ready traffic here. All control outputs
// are level signals consumed by the pipeline registers on the next rising
// edge; a control output high in a cycle means "apply this cycle".
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        d_rs1,
  input  logic [4:0]        d_rs2,
  input  logic              d_rs1_used,
  input  logic              d_rs2_used,
  input  logic              e_valid,
  input  logic [4:0]        e_rd,
  input  logic              e_is_load,
  input  logic              e_redirect,
  input  logic              m_regwren,
  input  logic [4:0]        m_rd,
  input  logic [DWIDTH-1:0] m_data,
  input  logic              w_regwren,
  input  logic [4:0]        w_rd,
  input  logic [DWIDTH-1:0] w_data,
  input  logic [DWIDTH-1:0] rf_rs1_data,
  input  logic [DWIDTH-1:0] rf_rs2_data,
  output logic [DWIDTH-1:0] rs1_data_o,
  output logic [DWIDTH-1:0] rs2_data_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic [1:0]        dbg_state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       flush_cycles_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Reload values: the detecting cycle is already one stall/flush cycle, so
  // the counter holds only the cycles still owed after it.
  localparam logic [1:0] LD_RELOAD = 2'((LOAD_LAT > 0) ? (LOAD_LAT - 1) : 0);
  localparam logic [1:0] BR_RELOAD = 2'((BR_PENALTY > 0) ? (BR_PENALTY - 1) : 0);
  // A sequence longer than the detecting cycle needs the FSM to leave RUN.
  localparam logic       LD_MULTI  = (LOAD_LAT > 1);
  localparam logic       BR_MULTI  = (BR_PENALTY > 1);
  localparam logic       LD_EN     = (LOAD_LAT > 0);

  state_t     r_state;
  logic [1:0] r_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_haz;
  logic w_in_stall;
  logic w_stall;
  logic w_flush;

  // ---------------------------------------------------------------------------
  // Operand forwarding. x0 passes the register file value through (the file
  // always returns zero there), so a MEM/WB write to x0 can never leak.
  // The *_used flags deliberately do not gate forwarding.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_data_o = rf_rs1_data;
    if (d_rs1 != 5'd0) begin
      if (m_regwren && (m_rd == d_rs1)) begin
        rs1_data_o = m_data;
      end else if (w_regwren && (w_rd == d_rs1)) begin
        rs1_data_o = w_data;
      end
    end
  end

  always_comb begin
    rs2_data_o = rf_rs2_data;
    if (d_rs2 != 5'd0) begin
      if (m_regwren && (m_rd == d_rs2)) begin
        rs2_data_o = m_data;
      end else if (w_regwren && (w_rd == d_rs2)) begin
        rs2_data_o = w_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------------------
  assign w_rs1_hit = d_rs1_used && (d_rs1 == e_rd);
  assign w_rs2_hit = d_rs2_used && (d_rs2 == e_rd);
  assign w_haz     = LD_EN && e_valid && e_is_load && (e_rd != 5'd0) &&
                     (w_rs1_hit || w_rs2_hit);

  // ---------------------------------------------------------------------------
  // Sequencing FSM. Outputs are decoded from the registered state plus the
  // current-cycle event, so a hazard or redirect acts in the cycle it is seen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (e_redirect) begin
            // Redirect beats a simultaneous hazard: the stalled instruction
            // is on the wrong path and is about to be flushed anyway.
            if (BR_MULTI) begin
              r_state <= ST_FLUSH;
              r_cnt   <= BR_RELOAD;
            end
          end else if (w_haz && LD_MULTI) begin
            r_state <= ST_STALL;
            r_cnt   <= LD_RELOAD;
          end
        end

        ST_STALL: begin
          if (e_redirect) begin
            // Abort the stall; the held instruction is squashed.
            if (BR_MULTI) begin
              r_state <= ST_FLUSH;
              r_cnt   <= BR_RELOAD;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= 2'd0;
            end
          end else if (r_cnt <= 2'd1) begin
            // Last owed cycle. EX is bubbled throughout the stall, so the
            // original hazard has cleared; any fresh load-use pair is caught
            // by RUN on the next cycle and gets the full latency.
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        ST_FLUSH: begin
          if (e_redirect) begin
            // A further redirect restarts the penalty from this cycle.
            if (BR_MULTI) begin
              r_cnt <= BR_RELOAD;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= 2'd0;
            end
          end else if (r_cnt <= 2'd1) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Hazards seen during FLUSH are ignored: only RUN-detected hazards and the
  // STALL state itself produce a stall, and any redirect suppresses it.
  assign w_in_stall = (r_state == ST_STALL) || ((r_state == ST_RUN) && w_haz);

  // Gating with rst makes every control output read 0 as soon as reset is
  // asserted, without waiting for a clock edge.
  assign w_stall = rst && !e_redirect && w_in_stall;
  assign w_flush = rst && (e_redirect || (r_state == ST_FLUSH));

  assign stall_f_o   = w_stall;
  assign stall_d_o   = w_stall;
  assign flush_d_o   = w_flush;
  assign flush_e_o   = w_flush || w_stall;
  assign dbg_state_o = r_state;

`ifdef HAZARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters, one count per stall/flush cycle issued.
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_cycles <= 32'd0;
    end else begin
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush && (r_flush_cycles != 32'hFFFF_FFFF)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_cycles_o = r_flush_cycles;
`endif

endmodule
